// File: rtl/nb_iot_chest_pkg.sv
// Shared constants, select encodings and sequencer state type for the
// NB-IoT channel-estimation interpolation path.
package nb_iot_chest_pkg;

  localparam logic [1:0] SEL_DIV2 = 2'b00;
  localparam logic [1:0] SEL_EST3 = 2'b01;
  localparam logic [1:0] SEL_DIV1 = 2'b10;
  localparam logic [1:0] SEL_EST4 = 2'b11;

  localparam int unsigned NSC_DEF  = 12;
  localparam int unsigned NSYM_DEF = 14;
  localparam int unsigned SYM_SLOT = 7;
  localparam int unsigned RS_OFF0  = 5;
  localparam int unsigned RS_OFF1  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYM,
    ST_DREQ,
    ST_DWAIT,
    ST_EMIT,
    ST_DONE
  } seq_state_t;

  function automatic logic is_rs_sym(input logic [3:0] sym);
    int unsigned r;
    r = 32'(sym) % SYM_SLOT;
    return (r == RS_OFF0) || (r == RS_OFF1);
  endfunction

  function automatic logic in_slot1(input logic [3:0] sym);
    return 32'(sym) >= SYM_SLOT;
  endfunction

endpackage

// File: rtl/interp_idx_cnt.sv
// Symbol/subcarrier position counter: sc runs fastest, sym advances when sc wraps.
module interp_idx_cnt
  import nb_iot_chest_pkg::*;
#(
  parameter int unsigned NSC  = NSC_DEF,
  parameter int unsigned NSYM = NSYM_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_sym,
  output logic [3:0] o_sc,
  output logic       o_last_sc,
  output logic       o_last_sym
);

  localparam logic [3:0] SC_LAST  = 4'(NSC - 1);
  localparam logic [3:0] SYM_LAST = 4'(NSYM - 1);

  logic [3:0] r_sym;
  logic [3:0] r_sc;

  assign o_sym      = r_sym;
  assign o_sc       = r_sc;
  assign o_last_sc  = (r_sc == SC_LAST);
  assign o_last_sym = (r_sym == SYM_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sym <= '0;
      r_sc  <= '0;
    end else if (i_inc) begin
      if (o_last_sc) begin
        r_sc  <= '0;
        r_sym <= o_last_sym ? '0 : r_sym + 4'd1;
      end else begin
        r_sc <= r_sc + 4'd1;
      end
    end
  end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Subframe sequencer: walks symbols/subcarriers, launches the shared divider for
// non-RS symbols and presents each mux sample over a valid/ready handshake.
module interp_seq_ctrl
  import nb_iot_chest_pkg::*;
#(
  parameter int unsigned NSC  = NSC_DEF,
  parameter int unsigned NSYM = NSYM_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       est_valid,
  input  logic       flush,
  output logic       div_start,
  output logic [3:0] div_sym,
  input  logic       div_done,
  output logic [1:0] sel,
  output logic       h_valid,
  input  logic       eq_ready,
  output logic [3:0] sym_idx,
  output logic [3:0] sc_idx,
  output logic       busy,
  output logic       sf_done
);

  seq_state_t r_state;
  logic       r_div_start;
  logic [3:0] r_div_sym;
  logic [1:0] r_sel;
  logic       r_h_valid;
  logic       r_busy;
  logic       r_sf_done;

  logic [3:0] w_sym;
  logic [3:0] w_sc;
  logic       w_last_sc;
  logic       w_last_sym;
  logic       w_xfer;
  logic       w_clr;
  logic       w_inc;

  assign w_xfer = (r_state == ST_EMIT) && r_h_valid && eq_ready;
  assign w_clr  = flush || ((r_state == ST_IDLE) && est_valid);
  assign w_inc  = w_xfer && !flush;

  interp_idx_cnt #(
    .NSC  (NSC),
    .NSYM (NSYM)
  ) u_idx_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .o_sym      (w_sym),
    .o_sc       (w_sc),
    .o_last_sc  (w_last_sc),
    .o_last_sym (w_last_sym)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div_start <= 1'b0;
      r_div_sym   <= '0;
      r_sel       <= SEL_DIV2;
      r_h_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_sf_done   <= 1'b0;
    end else if (flush) begin
      // sel is left as-is on flush; only reset returns it to the idle code
      r_state     <= ST_IDLE;
      r_div_start <= 1'b0;
      r_h_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_sf_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (est_valid) begin
            r_state <= ST_SYM;
            r_busy  <= 1'b1;
          end
        end
        ST_SYM: begin
          // sel is chosen here so it is already stable while waiting on the divider
          if (is_rs_sym(w_sym)) begin
            r_state   <= ST_EMIT;
            r_h_valid <= 1'b1;
            r_sel     <= in_slot1(w_sym) ? SEL_EST4 : SEL_EST3;
          end else begin
            r_state     <= ST_DREQ;
            r_div_start <= 1'b1;
            r_div_sym   <= w_sym;
            r_sel       <= in_slot1(w_sym) ? SEL_DIV2 : SEL_DIV1;
          end
        end
        ST_DREQ: begin
          r_div_start <= 1'b0;
          r_state     <= ST_DWAIT;
        end
        ST_DWAIT: begin
          if (div_done) begin
            r_state   <= ST_EMIT;
            r_h_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (w_xfer && w_last_sc) begin
            r_h_valid <= 1'b0;
            if (w_last_sym) begin
              r_state   <= ST_DONE;
              r_sf_done <= 1'b1;
            end else begin
              r_state <= ST_SYM;
            end
          end
        end
        ST_DONE: begin
          r_sf_done <= 1'b0;
          r_busy    <= 1'b0;
          r_sel     <= SEL_DIV2;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign div_start = r_div_start;
  assign div_sym   = r_div_sym;
  assign sel       = r_sel;
  assign h_valid   = r_h_valid;
  assign sym_idx   = w_sym;
  assign sc_idx    = w_sc;
  assign busy      = r_busy;
  assign sf_done   = r_sf_done;

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Bench for interp_seq_ctrl: directed scenarios plus a per-cycle reference model
// that predicts each sample position/select from the subframe layout.
module tb_interp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       est_valid = 1'b0;
  logic       flush = 1'b0;
  logic       eq_ready = 1'b1;
  logic       resp_dd = 1'b0;
  logic       spur_dd = 1'b0;
  logic       div_done;
  logic       div_start;
  logic [3:0] div_sym;
  logic [1:0] sel;
  logic       h_valid;
  logic [3:0] sym_idx;
  logic [3:0] sc_idx;
  logic       busy;
  logic       sf_done;

  assign div_done = resp_dd | spur_dd;

  interp_seq_ctrl #(.NSC(12), .NSYM(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .est_valid (est_valid),
    .flush     (flush),
    .div_start (div_start),
    .div_sym   (div_sym),
    .div_done  (div_done),
    .sel       (sel),
    .h_valid   (h_valid),
    .eq_ready  (eq_ready),
    .sym_idx   (sym_idx),
    .sc_idx    (sc_idx),
    .busy      (busy),
    .sf_done   (sf_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected select for the pos-th sample of a subframe (12 samples per symbol).
  function automatic int exp_sel(input int pos);
    int s;
    int r;
    s = pos / 12;
    r = s % 7;
    if (r == 5 || r == 6) return (s >= 7) ? 3 : 1;
    return (s >= 7) ? 0 : 2;
  endfunction

  int divlist [10] = '{0, 1, 2, 3, 4, 7, 8, 9, 10, 11};

  // Divider stand-in: div_done three cycles after div_start.
  int dd_cnt = 0;
  always @(posedge clk) begin
    #1;
    resp_dd = 1'b0;
    if (dd_cnt != 0) begin
      dd_cnt--;
      if (dd_cnt == 0) resp_dd = 1'b1;
    end
    if (div_start === 1'b1) dd_cnt = 3;
  end

  // Reference model state
  bit         mon_en = 0;
  bit         after_rst = 0;
  bit         after_flush = 0;
  bit         m_run = 0;
  bit         exp_busy = 0;
  bit         exp_sfdone = 0;
  bit         was_busy = 0;
  bit         prev_hold = 0;
  logic [3:0] p_sym;
  logic [3:0] p_sc;
  logic [1:0] p_sel;
  int         m_pos = 0;
  int         m_div = 0;
  int         xfer_cnt = 0;
  int         sfd_cnt = 0;
  int         first_hv = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", busy, exp_busy);
      check("sf_done", sf_done, exp_sfdone);
      if (after_rst) begin
        check("rst_sel", sel, 0);
        check("rst_h_valid", h_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_div_sym", div_sym, 0);
        check("rst_sym_idx", sym_idx, 0);
        check("rst_sc_idx", sc_idx, 0);
      end
      if (after_flush) begin
        check("flush_h_valid", h_valid, 0);
        check("flush_div_start", div_start, 0);
        check("flush_sym_idx", sym_idx, 0);
        check("flush_sc_idx", sc_idx, 0);
      end
      if (prev_hold) begin
        check("hold_h_valid", h_valid, 1);
        check("hold_sym", sym_idx, p_sym);
        check("hold_sc", sc_idx, p_sc);
        check("hold_sel", sel, p_sel);
      end
      if (h_valid === 1'b1) begin
        check("hv_in_run", m_run, 1);
        check("hv_sym", sym_idx, m_pos / 12);
        check("hv_sc", sc_idx, m_pos % 12);
        check("hv_sel", sel, exp_sel(m_pos));
        if (first_hv < 0) first_hv = cyc;
      end
      if (div_start === 1'b1) begin
        check("div_in_run", m_run, 1);
        check("div_sym_seq", div_sym, (m_div < 10) ? divlist[m_div] : 99);
        check("div_sym_cur", div_sym, m_pos / 12);
        m_div++;
      end
      if (sf_done === 1'b1) sfd_cnt++;
    end
    prev_hold   = 0;
    after_rst   = 0;
    after_flush = 0;
    if (rst) begin
      mon_en     = 1;
      after_rst  = 1;
      m_run      = 0;
      exp_busy   = 0;
      exp_sfdone = 0;
    end else if (flush) begin
      after_flush = 1;
      m_run       = 0;
      exp_busy    = 0;
      exp_sfdone  = 0;
    end else begin
      was_busy = exp_busy;
      if (exp_sfdone) begin
        exp_sfdone = 0;
        exp_busy   = 0;
      end
      if (h_valid === 1'b1 && eq_ready && m_run) begin
        m_pos++;
        xfer_cnt++;
        if (m_pos == 168) begin
          m_run      = 0;
          exp_sfdone = 1;
        end
      end
      if (h_valid === 1'b1 && !eq_ready) begin
        prev_hold = 1;
        p_sym     = sym_idx;
        p_sc      = sc_idx;
        p_sel     = sel;
      end
      if (est_valid && !was_busy) begin
        m_run    = 1;
        exp_busy = 1;
        m_pos    = 0;
        m_div    = 0;
        xfer_cnt = 0;
        sfd_cnt  = 0;
        first_hv = -1;
      end
    end
  end

  // Bounded wait; returns at posedge+1 of the cycle where the condition holds.
  task automatic wait_for(input int kind, input int a, input int b, input string nm);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    while (!hit && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      case (kind)
        0:       hit = (h_valid === 1'b1) && (sym_idx == 4'(a)) && (sc_idx == 4'(b));
        1:       hit = (div_start === 1'b1) && (div_sym == 4'(a));
        2:       hit = (sf_done === 1'b1);
        default: hit = (busy === 1'b0);
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_%s: got timeout expected event within 2000 cycles", nm);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    est_valid = 1'b1;
    tick(1);
    est_valid = 1'b0;
  endtask

  int t0;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);

    // Full subframe, always ready
    t0 = cyc;
    pulse_start();
    wait_for(2, 0, 0, "t1_sf_done");
    check("t1_first_hv_latency", first_hv - t0, 6);
    check("t1_sf_done_latency", cyc - t0, 223);
    check("t1_transfers", xfer_cnt, 168);
    check("t1_div_pulses", m_div, 10);
    tick(2);
    check("t1_sf_done_count", sfd_cnt, 1);

    // Stall at sym5/sc3; est_valid mid-subframe and in the DONE cycle
    pulse_start();
    wait_for(0, 2, 0, "t4_sym2");
    pulse_start();
    wait_for(0, 5, 3, "t2_sym5_sc3");
    eq_ready = 1'b0;
    tick(4);
    check("t2_hold_h_valid", h_valid, 1);
    check("t2_hold_sel", sel, 1);
    check("t2_hold_sym", sym_idx, 5);
    check("t2_hold_sc", sc_idx, 3);
    eq_ready = 1'b1;
    wait_for(2, 0, 0, "t2_sf_done");
    pulse_start();
    check("t4_idle_after_done", busy, 0);
    tick(2);
    check("t4_transfers", xfer_cnt, 168);
    check("t4_sf_done_count", sfd_cnt, 1);

    // Flush while waiting on the divider for sym8
    pulse_start();
    wait_for(1, 8, 0, "t3_div_sym8");
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_h_valid", h_valid, 0);
    check("t3_sf_done", sf_done, 0);
    tick(20);
    check("t3_no_sf_done", sfd_cnt, 0);
    pulse_start();
    wait_for(0, 0, 0, "t3_restart");
    check("t3_restart_sel", sel, 2);

    // Spurious div_done in EMIT and in IDLE
    wait_for(0, 1, 4, "t6_emit");
    spur_dd = 1'b1;
    tick(1);
    spur_dd = 1'b0;
    wait_for(2, 0, 0, "t6_sf_done");
    tick(2);
    check("t6_transfers", xfer_cnt, 168);
    check("t6_div_pulses", m_div, 10);
    spur_dd = 1'b1;
    tick(1);
    spur_dd = 1'b0;
    tick(4);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_h_valid", h_valid, 0);

    // Reset mid-subframe at sym12/sc7
    pulse_start();
    wait_for(0, 12, 7, "t5_sym12_sc7");
    check("t5_sel_before", sel, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_sel", sel, 0);
    check("t5_h_valid", h_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_sym_idx", sym_idx, 0);
    check("t5_sc_idx", sc_idx, 0);
    check("t5_sf_done", sf_done, 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
